fifo_inst_issuer: RTL and testbench

- Upstream command stage for the SPRAM-backed FIFO wrapper `instruction`. It generates the 34-bit `inst` word {WE, RE, DI} from a valid/ready write stream and a valid/ready read-request stream.
- Tracks FIFO occupancy and in-flight reads so the FIFO is never written when full, never read when empty, and never over-subscribed on read returns.
- Consumes `read_valid` from `instruction` to retire outstanding reads.

---
 rtl/fifo_inst_pkg.sv | 18 +
 rtl/sat_updown_cnt.sv | 58 +++++
 rtl/fifo_inst_issuer.sv | 104 ++++++++++
 tb/tb_fifo_inst_issuer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_inst_pkg.sv
// Shared definitions for the instruction FIFO command path: data width,
// layout of the {WE, RE, DI} inst word and a helper to build it.
package fifo_inst_pkg;

    localparam int DATA_W = 32;
    localparam int INST_W = DATA_W + 2;
    localparam int WE_BIT = DATA_W + 1;
    localparam int RE_BIT = DATA_W;

    function automatic logic [INST_W-1:0] pack_inst(
        input logic              we,
        input logic              re,
        input logic [DATA_W-1:0] di
    );
        return {we, re, di};
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Registered up/down counter clamped to 0..MAX, with registered flags for
// the two end points so downstream ready logic sees only flop outputs.
module sat_updown_cnt #(
    parameter int W   = 5,
    parameter int MAX = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         at_max,
    output logic         at_zero
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_cnt;
    logic         r_at_max;
    logic         r_at_zero;
    logic [W-1:0] w_cnt_nxt;

    // Next count: simultaneous inc and dec cancel; both ends clamp.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (inc && !dec && (r_cnt != MAX_V)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (dec && !inc && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // Count and end-point flags update together so they never disagree.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_at_max  <= 1'b0;
            r_at_zero <= 1'b1;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_at_max  <= (w_cnt_nxt == MAX_V);
            r_at_zero <= (w_cnt_nxt == '0);
        end
    end

    // Callers gate inc with at_max; an increment at the top is a caller bug.
    always @(posedge clk) begin
        if (rstn) begin
            assert (!(inc && !dec && r_at_max));
            assert (r_cnt <= MAX_V);
        end
    end

    assign cnt     = r_cnt;
    assign at_max  = r_at_max;
    assign at_zero = r_at_zero;

endmodule

// File: rtl/fifo_inst_issuer.sv
// Command stage in front of the SPRAM-backed instruction FIFO. Turns a
// write stream and a read-request stream into registered {WE, RE, DI}
// words, guarding against overflow, underflow and too many reads in flight.
// The data width is owned by fifo_inst_pkg so it always matches the FIFO.
module fifo_inst_issuer
    import fifo_inst_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int MAX_RD_OUT = 2,
    localparam int CNT_W      = $clog2(DEPTH) + 1,
    localparam int RDO_W      = $clog2(MAX_RD_OUT + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_wr_valid,
    output logic              s_wr_ready,
    input  logic [DATA_W-1:0] s_wr_data,
    input  logic              s_rd_valid,
    output logic              s_rd_ready,
    output logic [INST_W-1:0] inst,
    input  logic              read_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [RDO_W-1:0]  rd_outstanding,
    output logic              err_unexp_rv
);

    logic [INST_W-1:0] r_inst;
    logic              r_err;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_rv_ret;
    logic              w_full;
    logic              w_empty;
    logic              w_rd_at_max;
    logic              w_rd_zero;

    // A returning read frees budget in the same cycle, so a saturated read
    // budget still sustains one read per cycle while data keeps coming back.
    assign s_wr_ready = !w_full;
    assign s_rd_ready = !w_empty && (!w_rd_at_max || read_valid);
    assign w_wr_fire  = s_wr_valid && s_wr_ready;
    assign w_rd_fire  = s_rd_valid && s_rd_ready;

    // Only a read_valid that matches an issued read retires one; a stray one
    // is flagged and otherwise ignored so it cannot hide a real issue.
    assign w_rv_ret = read_valid && !w_rd_zero;

    sat_updown_cnt #(
        .W   (CNT_W),
        .MAX (DEPTH)
    ) u_occ_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (w_wr_fire),
        .dec     (w_rd_fire),
        .cnt     (count),
        .at_max  (w_full),
        .at_zero (w_empty)
    );

    sat_updown_cnt #(
        .W   (RDO_W),
        .MAX (MAX_RD_OUT)
    ) u_rdo_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (w_rd_fire),
        .dec     (w_rv_ret),
        .cnt     (rd_outstanding),
        .at_max  (w_rd_at_max),
        .at_zero (w_rd_zero)
    );

    // Issue register: WE/RE pulse for one cycle per handshake, DI holds the
    // last written word because the FIFO ignores it whenever WE is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inst <= pack_inst(1'b0, 1'b0, '0);
        end else begin
            r_inst[WE_BIT] <= w_wr_fire;
            r_inst[RE_BIT] <= w_rd_fire;
            if (w_wr_fire) begin
                r_inst[DATA_W-1:0] <= s_wr_data;
            end
        end
    end

    // Sticky flag for read_valid arriving with nothing outstanding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (read_valid & w_rd_zero);
        end
    end

    assign inst         = r_inst;
    assign full         = w_full;
    assign empty        = w_empty;
    assign err_unexp_rv = r_err;

endmodule

// File: tb/tb_fifo_inst_issuer.sv
// Bench for fifo_inst_issuer: directed scenarios plus a random phase, all
// checked against a queue-based model of FIFO contents and read budget.
module tb_fifo_inst_issuer;
    import fifo_inst_pkg::*;

    localparam int DEPTH = 16;
    localparam int MAXO  = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              s_wr_valid = 1'b0;
    logic              s_wr_ready;
    logic [DATA_W-1:0] s_wr_data = '0;
    logic              s_rd_valid = 1'b0;
    logic              s_rd_ready;
    logic [INST_W-1:0] inst;
    logic              read_valid = 1'b0;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic [1:0]        rd_outstanding;
    logic              err_unexp_rv;

    int total = 0;
    int bad   = 0;
    int re_seen = 0;

    logic [DATA_W-1:0] mq[$];
    int                m_out = 0;
    bit                m_err = 1'b0;
    bit                m_we = 1'b0;
    bit                m_re = 1'b0;
    logic [DATA_W-1:0] m_di = '0;

    fifo_inst_issuer #(
        .DEPTH      (DEPTH),
        .MAX_RD_OUT (MAXO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_wr_valid     (s_wr_valid),
        .s_wr_ready     (s_wr_ready),
        .s_wr_data      (s_wr_data),
        .s_rd_valid     (s_rd_valid),
        .s_rd_ready     (s_rd_ready),
        .inst           (inst),
        .read_valid     (read_valid),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .rd_outstanding (rd_outstanding),
        .err_unexp_rv   (err_unexp_rv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_out = 0;
        m_err = 1'b0;
        m_we  = 1'b0;
        m_re  = 1'b0;
        m_di  = '0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".inst"},  64'(inst),           64'(pack_inst(m_we, m_re, m_di)));
        chk({tag, ".count"}, 64'(count),          64'(mq.size()));
        chk({tag, ".full"},  64'(full),           64'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 64'(empty),          64'(mq.size() == 0));
        chk({tag, ".rdout"}, 64'(rd_outstanding), 64'(m_out));
        chk({tag, ".err"},   64'(err_unexp_rv),   64'(m_err));
    endtask

    // One clock cycle: drive at negedge, check readies, then check state.
    task automatic step(input bit wv, input logic [DATA_W-1:0] wd, input bit rq, input bit rv);
        bit wf, rf, ret;
        @(negedge clk);
        s_wr_valid = wv;
        s_wr_data  = wd;
        s_rd_valid = rq;
        read_valid = rv;
        #1;
        wf = wv && (mq.size() < DEPTH);
        rf = rq && (mq.size() > 0) && ((m_out < MAXO) || rv);
        chk("wr_ready", 64'(s_wr_ready), 64'(mq.size() < DEPTH));
        chk("rd_ready", 64'(s_rd_ready), 64'((mq.size() > 0) && ((m_out < MAXO) || rv)));
        @(posedge clk);
        #1;
        ret = rv && (m_out > 0);
        if (rv && (m_out == 0)) m_err = 1'b1;
        if (rf) void'(mq.pop_front());
        if (wf) begin
            mq.push_back(wd);
            m_di = wd;
        end
        m_out = m_out + int'(rf) - int'(ret);
        m_we  = wf;
        m_re  = rf;
        if (inst[RE_BIT]) re_seen++;
        chk_state("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn       = 1'b0;
        s_wr_valid = 1'b0;
        s_rd_valid = 1'b0;
        read_valid = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_state("reset");
        chk("reset.wr_ready", 64'(s_wr_ready), 64'(1));
        chk("reset.rd_ready", 64'(s_rd_ready), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int re_base;

        // Reset state
        do_reset();

        // Fill with 1..16, one write per cycle, then one held-off write
        for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
        chk("fill.count", 64'(count), 64'(16));
        chk("fill.full", 64'(full), 64'(1));
        step(1'b1, 32'h0000_0011, 1'b0, 1'b0);
        chk("fill.held_we", 64'(inst[WE_BIT]), 64'(0));

        // Drain with a read every cycle, data returned one cycle after RE
        re_base = re_seen;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, m_re);
        chk("drain.re_count", 64'(re_seen - re_base), 64'(16));
        chk("drain.empty", 64'(empty), 64'(1));

        // Empty with both valids: write first, read next cycle
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("both.first", 64'(inst), 64'(pack_inst(1'b1, 1'b0, 32'hDEAD_BEEF)));
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("both.second_re", 64'(inst[RE_BIT]), 64'(1));
        chk("both.second_cnt", 64'(count), 64'(1));

        // Build up to 8 entries and retire the pending read
        step(1'b1, 32'h1111_0001, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 32'h2222_0000 + DATA_W'(i), 1'b0, 1'b0);
        chk("budget.count8", 64'(count), 64'(8));

        // Read budget: two issues, then stall until one return
        re_base = re_seen;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("budget.two_re", 64'(re_seen - re_base), 64'(2));
        chk("budget.stalled", 64'(s_rd_ready), 64'(0));
        re_base = re_seen;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("budget.one_more", 64'(re_seen - re_base), 64'(1));
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Stray read_valid with nothing outstanding
        step(1'b0, '0, 1'b0, 1'b1);
        chk("stray.err", 64'(err_unexp_rv), 64'(1));
        chk("stray.count", 64'(count), 64'(5));
        chk("stray.rdout", 64'(rd_outstanding), 64'(0));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("stray.sticky", 64'(err_unexp_rv), 64'(1));

        // Random traffic with legal returns
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 (m_out > 0) && (1'($urandom_range(0, 1)) == 1'b1));
        end

        // Asynchronous reset mid-burst at count 5, then resume
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_00A0 + DATA_W'(i), 1'b0, 1'b0);
        @(negedge clk);
        s_wr_valid = 1'b1;
        s_wr_data  = 32'h0000_00A5;
        #2;
        rstn = 1'b0;
        #1;
        chk("async.inst", 64'(inst), 64'(0));
        chk("async.count", 64'(count), 64'(0));
        chk("async.empty", 64'(empty), 64'(1));
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rstn       = 1'b1;
        s_wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_00B0 + DATA_W'(i), 1'b0, 1'b0);
        chk("async.resume", 64'(count), 64'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
